// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampling edge/bit counters plus the frame FSM
// that sequences sampler, deserializer and start/parity/stop checkers.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  STP2,
  input  logic                  strt_glitch,
  input  logic                  Parity_Error,
  input  logic                  Stop_Error,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]      bit_cnt,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  framing_err,
  output logic                  break_det
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, ERR_CH, BRK_WAIT
  } state_t;

  localparam logic [PRESCALE_W-1:0] P_MIN    = PRESCALE_W'(4);
  localparam logic [BIT_W-1:0]      BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  state_t state, state_next;

  logic [PRESCALE_W-1:0] p_lat;
  logic [PRESCALE_W-1:0] p_clamped;
  logic                  par_en_lat;
  logic                  stp2_lat;
  logic                  stp_idx;
  logic                  perr;
  logic                  serr;
  logic                  zero;
  logic                  edge_done;
  logic                  in_frame;
  logic                  start_entry;

  assign p_clamped   = (PRESCALE < P_MIN) ? P_MIN : PRESCALE;
  assign edge_done   = (edge_cnt == (p_lat - PRESCALE_W'(1)));
  assign in_frame    = (state == START) || (state == DATA) ||
                       (state == PARITY) || (state == STOP);
  assign start_entry = (state_next == START) && (state != START);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    dat_samp_en = in_frame;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    parity_err  = 1'b0;
    framing_err = 1'b0;
    break_det   = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) state_next = START;
      end
      START: begin
        strt_chk_en = edge_done;
        if (edge_done) state_next = strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        deser_en = edge_done;
        if (edge_done && (bit_cnt == BIT_LAST))
          state_next = par_en_lat ? PARITY : STOP;
      end
      PARITY: begin
        par_chk_en = edge_done;
        if (edge_done) state_next = STOP;
      end
      STOP: begin
        stp_chk_en = edge_done;
        if (edge_done && (!stp2_lat || stp_idx)) state_next = ERR_CH;
      end
      ERR_CH: begin
        data_valid  = !perr && !serr;
        parity_err  = perr;
        framing_err = serr;
        break_det   = serr && zero;
        // A break must see the line return high before another frame may start
        if (serr && zero)  state_next = BRK_WAIT;
        else if (!RX_IN)   state_next = START;
        else               state_next = IDLE;
      end
      BRK_WAIT: begin
        if (RX_IN) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      p_lat      <= P_MIN;
      par_en_lat <= 1'b0;
      stp2_lat   <= 1'b0;
      stp_idx    <= 1'b0;
      perr       <= 1'b0;
      serr       <= 1'b0;
      zero       <= 1'b0;
    end else if (start_entry) begin
      // Frame configuration is frozen here for the whole frame
      p_lat      <= p_clamped;
      par_en_lat <= PAR_EN;
      stp2_lat   <= STP2;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      stp_idx    <= 1'b0;
      perr       <= 1'b0;
      serr       <= 1'b0;
      zero       <= 1'b1;
    end else begin
      if (in_frame) edge_cnt <= edge_done ? '0 : edge_cnt + 1'b1;
      else          edge_cnt <= '0;

      if ((state == START) && edge_done)
        bit_cnt <= '0;
      else if (deser_en)
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;

      if (stp_chk_en) stp_idx <= stp2_lat && !stp_idx;
      if (par_chk_en && Parity_Error) perr <= 1'b1;
      if (stp_chk_en && Stop_Error)   serr <= 1'b1;
      if (in_frame && RX_IN)          zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are described at bit level, expected
// strobes/results are queued per frame, and a negedge monitor checks them.
module tb_uart_rx_ctrl;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int BW = $clog2(DW);

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] PRESCALE = PW'(8);
  logic          PAR_EN = 1'b0;
  logic          STP2 = 1'b0;
  logic          strt_glitch = 1'b0;
  logic          Parity_Error = 1'b0;
  logic          Stop_Error = 1'b0;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic          data_valid, parity_err, framing_err, break_det;

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
    .PAR_EN(PAR_EN), .STP2(STP2), .strt_glitch(strt_glitch),
    .Parity_Error(Parity_Error), .Stop_Error(Stop_Error),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
    .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid), .parity_err(parity_err),
    .framing_err(framing_err), .break_det(break_det)
  );

  always #5 CLK = ~CLK;

  typedef struct { int cyc; int kind; int p; int bitc; } strb_t;  // kind: 0 start,1 data,2 parity,3 stop
  typedef struct { int cyc; bit dv; bit pe; bit fe; bit bd; } res_t;

  strb_t sq[$];
  res_t  rq[$];
  int    cyc = 0;
  int    vec = 0;
  int    errs = 0;
  bit    exp_samp = 1'b0;
  bit    mon_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin : monitor
    logic [3:0] s, exp_s, r, exp_r;
    strb_t e;
    res_t  x;
    if (mon_en && !RST) begin
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        vec++; errs++;
        $display("FAIL strobe_missed cyc=%0d: kind %0d required, not observed", sq[0].cyc, sq[0].kind);
        void'(sq.pop_front());
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        vec++; errs++;
        $display("FAIL result_missed cyc=%0d: result pulse required, not observed", rq[0].cyc);
        void'(rq.pop_front());
      end
      vec++;
      if (dat_samp_en !== exp_samp) begin
        errs++;
        $display("FAIL dat_samp_en cyc=%0d got=%b exp=%b", cyc, dat_samp_en, exp_samp);
      end
      s = {stp_chk_en, par_chk_en, deser_en, strt_chk_en};
      if (s != 4'b0) begin
        vec++;
        if (sq.size() == 0) begin
          errs++;
          $display("FAIL strobe_unexpected cyc=%0d got=%b exp=none", cyc, s);
        end else begin
          e = sq.pop_front();
          exp_s = 4'b0001 << e.kind;
          if (e.cyc != cyc || s !== exp_s || edge_cnt !== PW'(e.p - 1) ||
              (e.kind == 1 && bit_cnt !== BW'(e.bitc))) begin
            errs++;
            $display("FAIL strobe cyc=%0d got strobes=%b edge_cnt=%0d bit_cnt=%0d exp cyc=%0d strobes=%b edge_cnt=%0d bit_cnt=%0d",
                     cyc, s, edge_cnt, bit_cnt, e.cyc, exp_s, e.p - 1, e.bitc);
          end
        end
      end
      r = {data_valid, parity_err, framing_err, break_det};
      if (r != 4'b0) begin
        vec++;
        if (rq.size() == 0) begin
          errs++;
          $display("FAIL result_unexpected cyc=%0d got dv/pe/fe/bd=%b exp=none", cyc, r);
        end else begin
          x = rq.pop_front();
          exp_r = {x.dv, x.pe, x.fe, x.bd};
          if (x.cyc != cyc || r !== exp_r) begin
            errs++;
            $display("FAIL result cyc=%0d got dv/pe/fe/bd=%b exp cyc=%0d dv/pe/fe/bd=%b", cyc, r, x.cyc, exp_r);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    exp_samp = 1'b0;
    repeat (n) tick();
  endtask

  task automatic brk_hold(input int n);
    RX_IN = 1'b0;
    exp_samp = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    logic [PW+BW+9-1:0] outs;
    RST = 1'b1;
    #1;
    outs = {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
            stp_chk_en, data_valid, parity_err, framing_err, break_det};
    vec++;
    if (outs !== '0) begin
      errs++;
      $display("FAIL reset_outputs got=%b exp=0", outs);
    end
    exp_samp = 1'b0;
    RX_IN = 1'b1;
    strt_glitch = 1'b0; Parity_Error = 1'b0; Stop_Error = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // One frame starting at the current cycle t (RX_IN low seen in IDLE/ERR_CH at t).
  task automatic frame(input int p_req, input int data, input bit par_en, input bit stp2,
                       input bit perr_i, input bit serr_i, input int p_mid,
                       input int abort_bit, output bit brk);
    int p, nb, t, ac, b, kind;
    bit par, zero, ed;
    bit line[$];
    strb_t e;
    res_t  x;
    p = (p_req < 4) ? 4 : p_req;
    t = cyc;
    PRESCALE = PW'(p_req); PAR_EN = par_en; STP2 = stp2;
    line.push_back(1'b0);
    par = 1'b0;
    for (int i = 0; i < DW; i++) begin
      line.push_back(bit'((data >> i) & 1));
      par ^= bit'((data >> i) & 1);
    end
    if (par_en) line.push_back(par ^ perr_i);
    line.push_back(!serr_i);
    if (stp2) line.push_back(!serr_i);
    nb = line.size();
    zero = 1'b1;
    foreach (line[i]) if (line[i]) zero = 1'b0;
    ac = (abort_bit >= 0) ? t + 1 + p * (1 + abort_bit) + 2 : 32'h7fffffff;
    for (int i = 0; i < nb; i++) begin
      kind = (i == 0) ? 0 : (i <= DW) ? 1 : (par_en && i == DW + 1) ? 2 : 3;
      e.cyc = t + p * (i + 1); e.kind = kind; e.p = p; e.bitc = i - 1;
      if (e.cyc < ac) sq.push_back(e);
    end
    x.cyc = t + 1 + p * nb;
    x.pe = perr_i && par_en;
    x.fe = serr_i;
    x.dv = !x.pe && !serr_i;
    x.bd = serr_i && zero;
    brk = x.bd && (abort_bit < 0);
    if (x.cyc < ac) rq.push_back(x);
    for (int c = t; c <= t + p * nb; c++) begin
      if (c == ac) begin
        do_reset();
        return;
      end
      b = (c > t) ? (c - t - 1) / p : 0;
      ed = (c > t) && ((c - t) % p == 0);
      RX_IN = (c == t) ? 1'b0 : line[b];
      strt_glitch = 1'b0;
      Parity_Error = ed && par_en && (b == DW + 1) && perr_i;
      Stop_Error = ed && (b >= DW + 1 + int'(par_en)) && serr_i;
      exp_samp = (c > t);
      if (c == t + 1) begin
        if (p_mid >= 0) PRESCALE = PW'(p_mid);
        PAR_EN = 1'($urandom);
        STP2 = 1'($urandom);
      end
      tick();
    end
    exp_samp = 1'b0;
    Parity_Error = 1'b0; Stop_Error = 1'b0;
  endtask

  // Rejected start: line low for two cycles, start checker flags a glitch.
  task automatic glitch(input int p_req);
    int p, t;
    strb_t e;
    p = (p_req < 4) ? 4 : p_req;
    t = cyc;
    PRESCALE = PW'(p_req);
    e.cyc = t + p; e.kind = 0; e.p = p; e.bitc = 0;
    sq.push_back(e);
    for (int c = t; c <= t + p; c++) begin
      RX_IN = (c <= t + 1) ? 1'b0 : 1'b1;
      strt_glitch = (c == t + p);
      exp_samp = (c > t);
      tick();
    end
    strt_glitch = 1'b0;
    exp_samp = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    bit brk;
    int sel;
    #1 RST = 1'b1;
    #1;
    vec++;
    if ({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
         data_valid, parity_err, framing_err, break_det} !== '0) begin
      errs++;
      $display("FAIL initial_reset: outputs not all zero");
    end
    tick(); tick();
    RST = 1'b0;
    mon_en = 1'b1;
    idle(10);

    frame(8, 'hA5, 0, 0, 0, 0, -1, -1, brk);              // baseline
    idle(5);
    frame(16, 'h3C, 1, 1, 1, 0, -1, -1, brk);             // parity error, two stops
    idle(3);
    frame(16, 'h5A, 1, 1, 0, 0, -1, -1, brk);             // clean follow-up clears perr
    idle(3);
    frame(8, 'h00, 0, 0, 0, 1, -1, -1, brk);              // line held low: break
    brk_hold(8 * 20);
    idle(4);
    frame(8, 'h96, 0, 0, 0, 0, -1, -1, brk);
    idle(3);
    glitch(8);
    frame(8, 'h11, 1, 0, 0, 0, -1, -1, brk);              // immediately after glitch
    idle(3);
    frame(8, 'hC3, 0, 0, 0, 0, 12, -1, brk);              // PRESCALE changed mid-frame
    frame(12, 'h7E, 0, 1, 0, 0, -1, -1, brk);             // back-to-back at new prescale
    idle(3);
    frame(8, 'hF0, 0, 0, 0, 1, -1, -1, brk);              // framing error, not break
    idle(3);
    frame(8, 'h2B, 0, 0, 0, 0, -1, 3, brk);               // reset during data bit 3
    idle(5);
    frame(2, 'h81, 0, 0, 0, 0, -1, -1, brk);              // prescale 2 clamps to 4
    idle(4);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        glitch($urandom_range(2, 20));
      end else begin
        frame($urandom_range(2, 20), (sel == 1) ? 0 : $urandom_range(0, 255),
              1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
              (sel == 1) || ($urandom_range(0, 3) == 0), $urandom_range(2, 20), -1, brk);
        if (brk) begin
          brk_hold($urandom_range(1, 20));
          idle($urandom_range(1, 3));
        end else if ($urandom_range(0, 2) != 0) begin
          idle($urandom_range(1, 5));
        end
      end
    end
    idle(20);
    mon_en = 1'b0;
    foreach (sq[i]) begin
      vec++; errs++;
      $display("FAIL strobe_leftover cyc=%0d kind=%0d never seen", sq[i].cyc, sq[i].kind);
    end
    foreach (rq[i]) begin
      vec++; errs++;
      $display("FAIL result_leftover cyc=%0d never seen", rq[i].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
